// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes,
// funct codes, ULA controls, mux selectors and the per-state control vector.
package mcu_pkg;

  localparam int unsigned OP_W_DEF       = 6;
  localparam int unsigned FUNCT_W_DEF    = 6;
  localparam int unsigned ULA_CTRL_W_DEF = 3;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTYPE  = 4'd6,
    ALUWB  = 4'd7,
    BEQ    = 4'd8,
    IMMEX  = 4'd9,
    IMMWB  = 4'd10,
    JUMP   = 4'd11,
    JAL    = 4'd12,
    JR     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_JR  = 6'b001000;

  localparam logic [2:0] ULA_ADD  = 3'b010;
  localparam logic [2:0] ULA_SUB  = 3'b110;
  localparam logic [2:0] ULA_AND  = 3'b000;
  localparam logic [2:0] ULA_OR   = 3'b001;
  localparam logic [2:0] ULA_SLT  = 3'b111;
  localparam logic [2:0] ULA_IDLE = 3'b100;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ULA    = 2'b00;
  localparam logic [1:0] PCSRC_ULAOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       link;
    logic       ula_src_a;
    logic [1:0] ula_src_b;
    logic       imm_zero_ext;
    logic [2:0] ula_ctrl;
    logic [1:0] pc_src;
  } ctrl_t;

  function automatic ctrl_t idle_ctrl();
    ctrl_t c;
    c          = '0;
    c.ula_ctrl = ULA_IDLE;
    return c;
  endfunction

  // FETCH carries unqualified pc_write/ir_write; the top gates them with MemReady.
  function automatic ctrl_t state_ctrl(input state_t s, input logic [5:0] op,
                                       input logic [2:0] rtype_ula);
    ctrl_t c;
    c = idle_ctrl();
    case (s)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.ula_src_b = SRCB_FOUR;
        c.ula_ctrl  = ULA_ADD;
        c.pc_src    = PCSRC_ULA;
      end
      DECODE: begin
        c.ula_src_b = SRCB_IMM_SH;
        c.ula_ctrl  = ULA_ADD;
      end
      MEMADR: begin
        c.ula_src_a = 1'b1;
        c.ula_src_b = SRCB_IMM;
        c.ula_ctrl  = ULA_ADD;
      end
      MEMRD: begin
        c.iord     = 1'b1;
        c.mem_read = 1'b1;
      end
      MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      MEMWR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      RTYPE: begin
        c.ula_src_a = 1'b1;
        c.ula_src_b = SRCB_B;
        c.ula_ctrl  = rtype_ula;
      end
      ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      BEQ: begin
        c.ula_src_a = 1'b1;
        c.ula_src_b = SRCB_B;
        c.ula_ctrl  = ULA_SUB;
        c.branch    = 1'b1;
        c.pc_src    = PCSRC_ULAOUT;
      end
      IMMEX: begin
        c.ula_src_a = 1'b1;
        c.ula_src_b = SRCB_IMM;
        case (op)
          OP_ANDI: begin
            c.ula_ctrl     = ULA_AND;
            c.imm_zero_ext = 1'b1;
          end
          OP_ORI: begin
            c.ula_ctrl     = ULA_OR;
            c.imm_zero_ext = 1'b1;
          end
          default: c.ula_ctrl = ULA_ADD;
        endcase
      end
      IMMWB: c.reg_write = 1'b1;
      JUMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = PCSRC_JUMP;
      end
      JAL: begin
        c.pc_write  = 1'b1;
        c.pc_src    = PCSRC_JUMP;
        c.reg_write = 1'b1;
        c.link      = 1'b1;
      end
      JR: begin
        c.pc_write = 1'b1;
        c.pc_src   = PCSRC_REG;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle FSM (master) and its datapath (slave).
interface multicycle_control_fsm_if #(
  parameter int unsigned OP_W       = 6,
  parameter int unsigned FUNCT_W    = 6,
  parameter int unsigned ULA_CTRL_W = 3
);
  logic [OP_W-1:0]       OP;
  logic [FUNCT_W-1:0]    Funct;
  logic                  MemReady;
  logic                  PCWrite;
  logic                  Branch;
  logic                  IorD;
  logic                  MemRead;
  logic                  MemWrite;
  logic                  IRWrite;
  logic                  RegWrite;
  logic                  RegDst;
  logic                  MemtoReg;
  logic                  Link;
  logic [4:0]            LinkReg;
  logic                  ULASrcA;
  logic [1:0]            ULASrcB;
  logic                  ImmZeroExt;
  logic [ULA_CTRL_W-1:0] ULAControl;
  logic [1:0]            PCSrc;
  logic                  IllegalOp;
  logic [3:0]            State;

  modport master (
    input  OP, Funct, MemReady,
    output PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, RegWrite,
           RegDst, MemtoReg, Link, LinkReg, ULASrcA, ULASrcB, ImmZeroExt,
           ULAControl, PCSrc, IllegalOp, State
  );

  modport slave (
    output OP, Funct, MemReady,
    input  PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, RegWrite,
           RegDst, MemtoReg, Link, LinkReg, ULASrcA, ULASrcB, ImmZeroExt,
           ULAControl, PCSrc, IllegalOp, State
  );
endinterface

// File: rtl/multicycle_control_fsm_funct_decoder.sv
// Combinational R-type funct decode: ULA operation, jr detection, legality.
module funct_decoder
  import mcu_pkg::*;
#(
  parameter int unsigned FUNCT_W    = 6,
  parameter int unsigned ULA_CTRL_W = 3
) (
  input  logic [FUNCT_W-1:0]    funct,
  output logic [ULA_CTRL_W-1:0] ula_ctrl,
  output logic                  is_jr,
  output logic                  legal
);

  always_comb begin
    ula_ctrl = ULA_IDLE;
    is_jr    = 1'b0;
    legal    = 1'b1;
    case (funct)
      F_ADD:   ula_ctrl = ULA_ADD;
      F_SUB:   ula_ctrl = ULA_SUB;
      F_AND:   ula_ctrl = ULA_AND;
      F_OR:    ula_ctrl = ULA_OR;
      F_SLT:   ula_ctrl = ULA_SLT;
      F_JR:    is_jr    = 1'b1;
      default: legal    = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control FSM: sequences Fetch/Decode/Execute/Memory/Writeback
// and drives the datapath controls for a shared, ready-handshaked memory.
module multicycle_control_fsm
  import mcu_pkg::*;
#(
  parameter int unsigned OP_W        = 6,
  parameter int unsigned FUNCT_W     = 6,
  parameter int unsigned ULA_CTRL_W  = 3,
  parameter bit          MEM_WAIT_EN = 1'b1,
  parameter int unsigned LINK_REG    = 31
) (
  input logic                    clk,
  input logic                    rst,
  multicycle_control_fsm_if.master bus
);

  state_t                state;
  state_t                state_nxt;
  ctrl_t                 ctrl_q;
  ctrl_t                 ctrl_out;
  logic                  ready;
  logic                  decode_illegal;
  logic [OP_W-1:0]       op;
  logic [ULA_CTRL_W-1:0] f_ctrl;
  logic                  f_is_jr;
  logic                  f_legal;

  assign op    = bus.OP;
  assign ready = MEM_WAIT_EN ? bus.MemReady : 1'b1;

  funct_decoder #(
    .FUNCT_W    (FUNCT_W),
    .ULA_CTRL_W (ULA_CTRL_W)
  ) u_funct_decoder (
    .funct    (bus.Funct),
    .ula_ctrl (f_ctrl),
    .is_jr    (f_is_jr),
    .legal    (f_legal)
  );

  always_comb begin
    state_nxt      = state;
    decode_illegal = 1'b0;
    case (state)
      FETCH:  if (ready) state_nxt = DECODE;
      DECODE: begin
        case (op)
          OP_RTYPE: begin
            if (f_is_jr)      state_nxt = JR;
            else if (f_legal) state_nxt = RTYPE;
            else begin
              state_nxt      = FETCH;
              decode_illegal = 1'b1;
            end
          end
          OP_LW, OP_SW:              state_nxt = MEMADR;
          OP_BEQ:                    state_nxt = BEQ;
          OP_ADDI, OP_ANDI, OP_ORI:  state_nxt = IMMEX;
          OP_J:                      state_nxt = JUMP;
          OP_JAL:                    state_nxt = JAL;
          default: begin
            state_nxt      = FETCH;
            decode_illegal = 1'b1;
          end
        endcase
      end
      MEMADR: state_nxt = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  if (ready) state_nxt = MEMWB;
      MEMWR:  if (ready) state_nxt = FETCH;
      RTYPE:  state_nxt = ALUWB;
      IMMEX:  state_nxt = IMMWB;
      MEMWB, ALUWB, BEQ, IMMWB, JUMP, JAL, JR: state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  // The control vector is registered alongside the state by decoding the
  // next state, so ctrl_q always equals the Moore decode of the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FETCH;
      ctrl_q <= state_ctrl(FETCH, op, f_ctrl);
    end else begin
      state  <= state_nxt;
      ctrl_q <= state_ctrl(state_nxt, op, f_ctrl);
    end
  end

  always_comb begin
    ctrl_out          = ctrl_q;
    ctrl_out.ir_write = ctrl_q.ir_write & ready;
    if (state == FETCH) ctrl_out.pc_write = ctrl_q.pc_write & ready;
    if (rst) ctrl_out = idle_ctrl();
  end

  assign bus.PCWrite    = ctrl_out.pc_write;
  assign bus.Branch     = ctrl_out.branch;
  assign bus.IorD       = ctrl_out.iord;
  assign bus.MemRead    = ctrl_out.mem_read;
  assign bus.MemWrite   = ctrl_out.mem_write;
  assign bus.IRWrite    = ctrl_out.ir_write;
  assign bus.RegWrite   = ctrl_out.reg_write;
  assign bus.RegDst     = ctrl_out.reg_dst;
  assign bus.MemtoReg   = ctrl_out.mem_to_reg;
  assign bus.Link       = ctrl_out.link;
  assign bus.LinkReg    = ctrl_out.link ? 5'(LINK_REG) : '0;
  assign bus.ULASrcA    = ctrl_out.ula_src_a;
  assign bus.ULASrcB    = ctrl_out.ula_src_b;
  assign bus.ImmZeroExt = ctrl_out.imm_zero_ext;
  assign bus.ULAControl = ctrl_out.ula_ctrl;
  assign bus.PCSrc      = ctrl_out.pc_src;
  assign bus.IllegalOp  = decode_illegal & ~rst;
  assign bus.State      = rst ? '0 : state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: stimulus pushes expected output
// vectors, a negedge monitor pops and compares them against both instances.
module tb_multicycle_control_fsm;

  localparam int S_IDLE = -1;
  localparam int S_F = 0, S_D = 1, S_MA = 2, S_MR = 3, S_MWB = 4, S_MW = 5;
  localparam int S_RT = 6, S_AWB = 7, S_BEQ = 8, S_IX = 9, S_IWB = 10;
  localparam int S_J = 11, S_JAL = 12, S_JR = 13;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQI = 6'b000100, ADDI = 6'b001000, ANDI = 6'b001100;
  localparam logic [5:0] ORI = 6'b001101, JI = 6'b000010, JALI = 6'b000011;
  localparam logic [5:0] BADOP = 6'b111111;
  localparam logic [5:0] FADD = 6'b100000, FSUB = 6'b100010, FAND = 6'b100100;
  localparam logic [5:0] FOR = 6'b100101, FSLT = 6'b101010, FJR = 6'b001000;

  typedef struct {
    string       nm;
    logic [28:0] e;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t q1[$];
  exp_t q2[$];
  exp_t x;

  always #5 clk = ~clk;

  multicycle_control_fsm_if ifa ();
  multicycle_control_fsm_if ifb ();

  multicycle_control_fsm #(.MEM_WAIT_EN(1'b1), .LINK_REG(31)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (ifa.master)
  );

  multicycle_control_fsm #(.MEM_WAIT_EN(1'b0), .LINK_REG(31)) u_dut_nowait (
    .clk (clk),
    .rst (rst),
    .bus (ifb.master)
  );

  function automatic logic [28:0] obs(input int which);
    if (which == 0)
      return {ifa.State, ifa.PCWrite, ifa.Branch, ifa.IorD, ifa.MemRead, ifa.MemWrite,
              ifa.IRWrite, ifa.RegWrite, ifa.RegDst, ifa.MemtoReg, ifa.Link, ifa.ULASrcA,
              ifa.ULASrcB, ifa.ImmZeroExt, ifa.ULAControl, ifa.PCSrc, ifa.IllegalOp,
              ifa.LinkReg};
    return {ifb.State, ifb.PCWrite, ifb.Branch, ifb.IorD, ifb.MemRead, ifb.MemWrite,
            ifb.IRWrite, ifb.RegWrite, ifb.RegDst, ifb.MemtoReg, ifb.Link, ifb.ULASrcA,
            ifb.ULASrcB, ifb.ImmZeroExt, ifb.ULAControl, ifb.PCSrc, ifb.IllegalOp,
            ifb.LinkReg};
  endfunction

  // Expected output vector per state, written out from the control table.
  function automatic logic [28:0] E(input int st, input bit rdy = 1'b1,
                                    input logic [2:0] ula = 3'b100,
                                    input bit zx = 1'b0, input bit ill = 1'b0);
    logic pcw = 0, br = 0, iord = 0, mr = 0, mw = 0, irw = 0, rw = 0, rd = 0;
    logic m2r = 0, lk = 0, sa = 0, zext = 0, il = 0;
    logic [1:0] sb = 2'b00, ps = 2'b00;
    logic [2:0] uc = 3'b100;
    logic [4:0] lr = 5'd0;
    logic [3:0] sv;
    sv = (st < 0) ? 4'd0 : 4'(st);
    case (st)
      S_F:   begin pcw = rdy; irw = rdy; mr = 1; sb = 2'b01; uc = 3'b010; end
      S_D:   begin sb = 2'b11; uc = 3'b010; il = ill; end
      S_MA:  begin sa = 1; sb = 2'b10; uc = 3'b010; end
      S_MR:  begin iord = 1; mr = 1; end
      S_MWB: begin rw = 1; m2r = 1; end
      S_MW:  begin iord = 1; mw = 1; end
      S_RT:  begin sa = 1; sb = 2'b00; uc = ula; end
      S_AWB: begin rw = 1; rd = 1; end
      S_BEQ: begin sa = 1; uc = 3'b110; br = 1; ps = 2'b01; end
      S_IX:  begin sa = 1; sb = 2'b10; uc = ula; zext = zx; end
      S_IWB: rw = 1;
      S_J:   begin pcw = 1; ps = 2'b10; end
      S_JAL: begin pcw = 1; ps = 2'b10; rw = 1; lk = 1; lr = 5'd31; end
      S_JR:  begin pcw = 1; ps = 2'b11; end
      default: ;
    endcase
    return {sv, pcw, br, iord, mr, mw, irw, rw, rd, m2r, lk, sa, sb, zext, uc, ps, il, lr};
  endfunction

  task automatic step(input logic [5:0] op, input logic [5:0] f, input bit rdy,
                      input bit r, input string nm, input logic [28:0] e1,
                      input bit c2 = 1'b0, input logic [28:0] e2 = '0);
    exp_t t;
    ifa.OP       = op;
    ifa.Funct    = f;
    ifa.MemReady = rdy;
    ifb.OP       = op;
    ifb.Funct    = f;
    rst          = r;
    t.nm = nm;
    t.e  = e1;
    q1.push_back(t);
    if (c2) begin
      t.e = e2;
      q2.push_back(t);
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (q1.size() > 0) begin
      x = q1.pop_front();
      checks++;
      if (obs(0) !== x.e) begin
        errors++;
        $display("FAIL %s: got %h required %h", x.nm, obs(0), x.e);
      end
    end
    if (q2.size() > 0) begin
      x = q2.pop_front();
      checks++;
      if (obs(1) !== x.e) begin
        errors++;
        $display("FAIL %s (no-wait): got %h required %h", x.nm, obs(1), x.e);
      end
    end
  end

  initial begin
    logic [5:0] rfun[3];
    logic [2:0] rula[3];
    logic [5:0] iop[3];
    logic [2:0] iula[3];
    bit         izx[3];
    rfun = '{FAND, FOR, FSLT};
    rula = '{3'b000, 3'b001, 3'b111};
    iop  = '{ADDI, ANDI, ORI};
    iula = '{3'b010, 3'b000, 3'b001};
    izx  = '{1'b0, 1'b1, 1'b1};

    ifa.OP = '0; ifa.Funct = '0; ifa.MemReady = 1'b0;
    ifb.OP = '0; ifb.Funct = '0; ifb.MemReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step(RT, FADD, 1, 1, "reset idle", E(S_IDLE));

    // lw, no wait: 5 cycles
    step(LW, 0, 1, 0, "lw fetch",  E(S_F, 1));
    step(LW, 0, 1, 0, "lw decode", E(S_D));
    step(LW, 0, 1, 0, "lw memadr", E(S_MA));
    step(LW, 0, 1, 0, "lw memrd",  E(S_MR));
    step(LW, 0, 1, 0, "lw memwb",  E(S_MWB));

    // fetch stalls 3 cycles, then add; then sub
    for (int i = 0; i < 3; i++) step(RT, FADD, 0, 0, "fetch wait", E(S_F, 0));
    step(RT, FADD, 1, 0, "fetch go",   E(S_F, 1));
    step(RT, FADD, 1, 0, "add decode", E(S_D));
    step(RT, FADD, 1, 0, "add rtype",  E(S_RT, 1, 3'b010));
    step(RT, FADD, 1, 0, "add aluwb",  E(S_AWB));
    step(RT, FSUB, 1, 0, "sub fetch",  E(S_F, 1));
    step(RT, FSUB, 1, 0, "sub decode", E(S_D));
    step(RT, FSUB, 1, 0, "sub rtype",  E(S_RT, 1, 3'b110));
    step(RT, FSUB, 1, 0, "sub aluwb",  E(S_AWB));
    for (int i = 0; i < 3; i++) begin
      step(RT, rfun[i], 1, 0, "rtype fetch",  E(S_F, 1));
      step(RT, rfun[i], 1, 0, "rtype decode", E(S_D));
      step(RT, rfun[i], 1, 0, "rtype exec",   E(S_RT, 1, rula[i]));
      step(RT, rfun[i], 1, 0, "rtype wb",     E(S_AWB));
    end

    // 3-cycle control transfers
    step(JALI, 0, 1, 0, "jal fetch",  E(S_F, 1));
    step(JALI, 0, 1, 0, "jal decode", E(S_D));
    step(JALI, 0, 1, 0, "jal exec",   E(S_JAL));
    step(RT, FJR, 1, 0, "jr fetch",   E(S_F, 1));
    step(RT, FJR, 1, 0, "jr decode",  E(S_D));
    step(RT, FJR, 1, 0, "jr exec",    E(S_JR));
    step(BEQI, 0, 1, 0, "beq fetch",  E(S_F, 1));
    step(BEQI, 0, 1, 0, "beq decode", E(S_D));
    step(BEQI, 0, 1, 0, "beq exec",   E(S_BEQ));
    step(JI, 0, 1, 0, "j fetch",      E(S_F, 1));
    step(JI, 0, 1, 0, "j decode",     E(S_D));
    step(JI, 0, 1, 0, "j exec",       E(S_J));

    // immediate ops
    for (int i = 0; i < 3; i++) begin
      step(iop[i], 0, 1, 0, "imm fetch",  E(S_F, 1));
      step(iop[i], 0, 1, 0, "imm decode", E(S_D));
      step(iop[i], 0, 1, 0, "imm exec",   E(S_IX, 1, iula[i], izx[i]));
      step(iop[i], 0, 1, 0, "imm wb",     E(S_IWB));
    end

    // sw with two wait cycles in MEMWR
    step(SW, 0, 1, 0, "sw fetch",  E(S_F, 1));
    step(SW, 0, 1, 0, "sw decode", E(S_D));
    step(SW, 0, 1, 0, "sw memadr", E(S_MA));
    step(SW, 0, 0, 0, "sw wait",   E(S_MW));
    step(SW, 0, 0, 0, "sw wait",   E(S_MW));
    step(SW, 0, 1, 0, "sw commit", E(S_MW));

    // illegal opcode and illegal funct
    step(BADOP, 0, 1, 0, "badop fetch",    E(S_F, 1));
    step(BADOP, 0, 1, 0, "badop decode",   E(S_D, 1, 3'b100, 0, 1));
    step(RT, 6'b000000, 1, 0, "badfn fetch",  E(S_F, 1));
    step(RT, 6'b000000, 1, 0, "badfn decode", E(S_D, 1, 3'b100, 0, 1));

    // reset mid-write aborts the store
    step(SW, 0, 1, 0, "rstw fetch",  E(S_F, 1));
    step(SW, 0, 1, 0, "rstw decode", E(S_D));
    step(SW, 0, 1, 0, "rstw memadr", E(S_MA));
    step(SW, 0, 0, 0, "rstw memwr",  E(S_MW));
    step(SW, 0, 0, 1, "rstw reset",  E(S_IDLE));
    step(SW, 0, 0, 0, "rstw after",  E(S_F, 0));

    // no-wait instance: sw in 4 cycles with MemReady tied low
    step(SW, 0, 0, 1, "nw reset",  E(S_IDLE), 1, E(S_IDLE));
    step(SW, 0, 0, 0, "nw fetch",  E(S_F, 0), 1, E(S_F, 1));
    step(SW, 0, 0, 0, "nw decode", E(S_F, 0), 1, E(S_D));
    step(SW, 0, 0, 0, "nw memadr", E(S_F, 0), 1, E(S_MA));
    step(SW, 0, 0, 0, "nw memwr",  E(S_F, 0), 1, E(S_MW));
    step(SW, 0, 0, 0, "nw next",   E(S_F, 0), 1, E(S_F, 1));

    @(negedge clk);
    #1;
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending required 0", q1.size() + q2.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multicycle successor to the single-cycle MIPS control decoder. It sequences each instruction through Fetch/Decode/Execute/Memory/Writeback states. A single shared memory with a ready handshake is supported. Per-state datapath controls are driven for the multicycle datapath: PC, IR, A/B/ULAOut registers and one ULA. Supported opcodes are R-type (add, sub, and, or, slt, jr), lw, sw, beq, addi, andi, ori, j and jal. Unsupported opcodes are flagged.

Parameters:
OP_W, 6, opcode field width
FUNCT_W, 6, funct field width
ULA_CTRL_W, 3, ULA control width
MEM_WAIT_EN, 1, 1 = honour MemReady; 0 = treat MemReady as constant 1
LINK_REG, 31, register index driven on LinkReg for jal

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
OP  in  OP_W  opcode from the IR
Funct  in  FUNCT_W  funct from the IR
MemReady  in  1  memory completes the access this cycle
PCWrite  out  1  unconditional PC load
Branch  out  1  PC load if ULA Zero
IorD  out  1  memory address: 0 = PC, 1 = ULAOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  IR load
RegWrite  out  1  register-file write
RegDst  out  1  write register: 0 = rt, 1 = rd
MemtoReg  out  1  write data: 0 = ULAOut, 1 = MDR
Link  out  1  write LINK_REG with PC (jal)
ULASrcA  out  1  ULA A input: 0 = PC, 1 = A
ULASrcB  out  2  ULA B input: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
ImmZeroExt  out  1  zero-extend the immediate (andi/ori)
ULAControl  out  ULA_CTRL_W  010 add, 110 sub, 000 and, 001 or, 111 slt, 100 idle
PCSrc  out  2  00 = ULA result, 01 = ULAOut, 10 = jump target, 11 = register A
IllegalOp  out  1  one-cycle pulse on an unsupported opcode or funct
State  out  4  current state, for debug

Behaviour:
- Moore outputs decoded from State, except that MemReady qualifies the enables marked (R).
- rst sampled high at clk: State <= FETCH.
- While rst is high, all outputs are at idle: all 0, ULAControl = 100.
- Reset in any state, including mid-access, aborts the instruction without any write.
- Idle vector is every output not listed for a state (all 0, ULAControl = 100).
- FETCH:
  - Outputs: IorD = 0, MemRead = 1, ULASrcA = 0, ULASrcB = 01, ULAControl = 010, PCSrc = 00.
  - IRWrite and PCWrite = MemReady (R).
  - Stays in FETCH while MemReady = 0; goes to DECODE when it is 1.
- DECODE:
  - Outputs: ULASrcA = 0, ULASrcB = 11, ULAControl = 010 (branch target into ULAOut).
  - Next state by OP:
    - 000000 -> JR if Funct = 001000; RTYPE if Funct is one of 100000/100010/100100/100101/101010.
    - 000000 with any other Funct -> FETCH with IllegalOp = 1.
    - 100011 or 101011 -> MEMADR.
    - 000100 -> BEQ.
    - 001000, 001100 or 001101 -> IMMEX.
    - 000010 -> JUMP.
    - 000011 -> JAL.
    - Any other OP -> FETCH with IllegalOp = 1.
- MEMADR:
  - Outputs: ULASrcA = 1, ULASrcB = 10, ULAControl = 010.
  - Next: MEMRD if lw, MEMWR if sw.
- MEMRD:
  - Outputs: IorD = 1, MemRead = 1.
  - Waits on MemReady, then goes to MEMWB.
- MEMWB:
  - Outputs: RegWrite = 1, RegDst = 0, MemtoReg = 1.
  - Next: FETCH.
- MEMWR:
  - Outputs: IorD = 1, MemWrite = 1 (held until ready).
  - Goes to FETCH on MemReady. The memory commits on the ready cycle only.
- RTYPE:
  - Outputs: ULASrcA = 1, ULASrcB = 00.
  - ULAControl from Funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - Next: ALUWB.
- ALUWB:
  - Outputs: RegWrite = 1, RegDst = 1, MemtoReg = 0.
  - Next: FETCH.
- BEQ:
  - Outputs: ULASrcA = 1, ULASrcB = 00, ULAControl = 110, Branch = 1, PCSrc = 01.
  - Next: FETCH.
- IMMEX:
  - Outputs: ULASrcA = 1, ULASrcB = 10.
  - addi: ULAControl = 010. andi: 000 with ImmZeroExt = 1. ori: 001 with ImmZeroExt = 1.
  - Next: IMMWB.
- IMMWB:
  - Outputs: RegWrite = 1, RegDst = 0, MemtoReg = 0.
  - Next: FETCH.
- JUMP:
  - Outputs: PCWrite = 1, PCSrc = 10.
  - Next: FETCH.
- JAL:
  - Outputs: PCWrite = 1, PCSrc = 10, RegWrite = 1, Link = 1. PC already holds PC+4 when it is written to LINK_REG.
  - Next: FETCH.
- JR:
  - Outputs: PCWrite = 1, PCSrc = 11.
  - Next: FETCH.
- Latency with MemReady = 1: beq, j, jal, jr = 3 cycles; R-type, sw, I-type = 4 cycles; lw = 5 cycles. Each wait cycle adds 1.
- MEM_WAIT_EN = 0 forces MemReady to be treated as 1.
- OP and Funct are sampled only in DECODE and in states that decode them. The IR is stable after FETCH.
- Unused state encodings (14, 15) go to FETCH with all outputs idle.

Decomposition:
- Package mcu_pkg holds:
  - state encodings (FETCH = 0, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE, ALUWB, BEQ, IMMEX, IMMWB, JUMP, JAL, JR = 13);
  - opcode and funct constants;
  - ULAControl codes;
  - ULASrcB and PCSrc selector codes.
- One sub-module, funct_decoder, is combinational: Funct -> ULAControl, is_jr and legal. It is reused in DECODE and RTYPE.

Test Plan:
- lw (OP = 100011), MemReady = 1 -> State sequence 0,1,2,3,4,0 over 5 cycles; RegWrite = 1, MemtoReg = 1 only in cycle 5.
- Fetch with MemReady low for 3 cycles, then high -> State stays 0 for 4 cycles; IRWrite and PCWrite are 1 only in the 4th cycle; DECODE follows.
- add (Funct = 100000) then sub (Funct = 100010) -> RTYPE ULAControl = 010, then 110; ALUWB has RegDst = 1, RegWrite = 1.
- jal -> 3 cycles; the JAL state drives PCWrite = 1, PCSrc = 10, Link = 1, RegWrite = 1. jr (Funct = 001000) -> the JR state drives PCSrc = 11.
- OP = 111111 -> IllegalOp = 1 for exactly 1 cycle in DECODE, then FETCH; no RegWrite or MemWrite occurs.
- rst asserted during MEMWR with MemReady = 0 -> next cycle State = 0 and MemWrite = 0. With MEM_WAIT_EN = 0 and MemReady tied to 0, sw completes in 4 cycles.
